// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared state and request-kind encodings for the ARM memory responder.
//   state_t : IDLE (no transaction), WAIT (latency count), RESP (ready cycle)
//   kind_t  : RD (read request), WR (write request)
package arm_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic {RD, WR} kind_t;
endpackage

// File: rtl/arm_mem_sram_1rw.sv
// arm_mem_sram_1rw: single-port DEPTH_WORDS x DATA_WIDTH storage, synchronous write, combinational read.
//   clk   in  clock
//   we    in  write enable, sampled on rising edge
//   addr  in  word index
//   wdata in  write data
//   rdata out read data for addr (combinational)
module arm_mem_sram_1rw #(
  parameter int DEPTH_WORDS = 1024,
  parameter int DATA_WIDTH  = 32,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/arm_mem_responder.sv
// arm_mem_responder: core-bus memory responder with WAIT_STATES latency, one-cycle ready pulse and error flagging.
//   clk       in  clock
//   reset_n   in  asynchronous active-low reset
//   mem_addr  in  byte address, held until ready
//   mem_wdata in  write data, held until ready
//   mem_read  in  read request level
//   mem_write in  write request level
//   mem_rdata out read data, valid with mem_ready
//   mem_ready out one-cycle completion pulse
//   mem_err   out error qualifier, valid with mem_ready
//   busy      out transaction in flight
module arm_mem_responder
  import arm_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_err,
  output logic                  busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  state_t state, nxt;
  kind_t kind_q, cur_kind;
  logic both_q, cur_both, err_q, cur_err, go_resp, req, we;
  logic [ADDR_WIDTH-1:0] addr_q, cur_addr;
  logic [DATA_WIDTH-1:0] wdata_q, cur_wdata, sram_rdata;
  logic [3:0] cnt, cnt_nxt;
  assign req = mem_read | mem_write;
  // With zero wait states the commit edge is the acceptance edge, so the live inputs stand in for the latches.
  assign cur_addr  = state == IDLE ? mem_addr : addr_q;
  assign cur_wdata = state == IDLE ? mem_wdata : wdata_q;
  assign cur_kind  = state == IDLE ? kind_t'(mem_write) : kind_q;
  assign cur_both  = state == IDLE ? mem_read & mem_write : both_q;
  // Any address bit above the word index means the access is past the end of storage.
  assign cur_err = (cur_addr[1:0] != 2'b00) | ((cur_addr >> (AW + 2)) != '0) | cur_both;
  assign we = reset_n & go_resp & (cur_kind == WR) & ~cur_err;
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    go_resp = 1'b0;
    case (state)
      IDLE: if (req) begin
        cnt_nxt = '0;
        nxt = WS == 4'd0 ? RESP : WAIT;
        go_resp = WS == 4'd0;
      end
      WAIT: begin
        cnt_nxt = cnt + 4'd1;
        go_resp = cnt_nxt == WS;
        nxt = go_resp ? RESP : WAIT;
      end
      RESP: begin
        cnt_nxt = '0;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr_q <= '0;
      wdata_q <= '0;
      kind_q <= RD;
      both_q <= 1'b0;
      err_q <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if (state == IDLE && req) begin
        addr_q <= mem_addr;
        wdata_q <= mem_wdata;
        kind_q <= kind_t'(mem_write);
        both_q <= mem_read & mem_write;
      end
      if (go_resp) begin
        err_q <= cur_err;
        if (cur_err) mem_rdata <= '0;
        else if (cur_kind == RD) mem_rdata <= sram_rdata;
      end
    end
  assign mem_ready = state == RESP;
  assign mem_err = mem_ready & err_q;
  assign busy = state != IDLE;
  arm_mem_sram_1rw #(.DEPTH_WORDS(DEPTH_WORDS), .DATA_WIDTH(DATA_WIDTH)) u_sram (
    .clk(clk),
    .we(we),
    .addr(cur_addr[AW+1:2]),
    .wdata(cur_wdata),
    .rdata(sram_rdata)
  );
endmodule
